uart_tx_fifo: RTL and testbench

Parametrised UART transmitter. It is the next generation of the team's fixed 8-bit, even-parity, 2-stop transmitter. Words arrive over a valid/ready interface into an internal FIFO. Each word is serialised LSB-first, gated by an external baud tick, with run-time selectable parity and stop-bit count. It sits between a host-side producer and the serial pin, and supports back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode encodings, transmitter state enum and parity helper shared by the UART blocks.
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_e;

  // red is the XOR reduction of the data word
  function automatic logic parity_bit(input logic [1:0] mode, input logic red);
    return mode == PAR_ODD ? ~red : mode == PAR_MARK ? 1'b1 : red;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with full/empty/level; head word is readable combinationally.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;

  assign level   = LVL_W'(wr_q - rd_q);
  assign full    = level == LVL_W'(FIFO_DEPTH);
  assign empty   = wr_q == rd_q;
  assign rd_data = mem_q[rd_q[PTR_W-1:0]];

  // pushes are refused on full regardless of a simultaneous pop
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[PTR_W-1:0]] = wr_data;
    wr_d = wr_q + {{PTR_W{1'b0}}, do_push};
    rd_d = rd_q + {{PTR_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with baud-tick pacing, selectable parity and stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              txd,
  output logic              busy,
  output logic              frame_done,
  output logic [LVL_W-1:0]  fifo_level
);
  localparam int CNT_W = $clog2(DATA_W);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, head;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              stop2_q, stop2_d, par_q, par_d;
  logic              txd_q, txd_d, busy_q, busy_d, done_q, done_d;
  logic              load, full, empty;

  assign in_ready   = !full;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(in_valid), .pop(load), .wr_data(in_data),
    .rd_data(head), .full(full), .empty(empty), .level(fifo_level)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    stop2_d = stop2_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: load = !empty;
        START: begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
        DATA: begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = mode_q != PAR_NONE ? PARITY : STOP1;
            txd_d   = mode_q != PAR_NONE ? par_q : 1'b1;
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          state_d = STOP1;
          txd_d   = 1'b1;
        end
        STOP1, STOP2: begin
          if (state_q == STOP1 && stop2_q) begin
            state_d = STOP2;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
            load    = !empty;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // a frame start latches config so mid-frame changes wait for the next frame
    if (load) begin
      state_d = START;
      shift_d = head;
      mode_d  = parity_mode;
      stop2_d = stop2;
      par_d   = parity_bit(parity_mode, ^head);
      txd_d   = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      mode_q  <= PAR_NONE;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; expected txd bit strings are queued per push and checked on each baud tick.
module tb_uart_tx_fifo;
  logic       clk = 1'b0, reset = 1'b1, baud_tick = 1'b0, in_valid = 1'b0, stop2 = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] parity_mode = '0;
  logic       txd, in_ready, busy, frame_done;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0, done_cnt = 0, fall_cnt = 0, tick_cnt = 0;
  bit tick_en = 1'b0, mon_en = 1'b1;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .parity_mode(parity_mode), .stop2(stop2), .txd(txd), .busy(busy),
    .frame_done(frame_done), .fifo_level(fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_bits(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i) == "1");
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      check({name, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_ticks(input int k);
    int target = tick_cnt + k;
    int n = 0;
    while (tick_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tick_cnt < target) check("tick_timeout", tick_cnt, target);
  endtask

  task automatic stop_ticks();
    tick_en = 1'b0;
    @(negedge clk);
  endtask

  // one tick every 16 clocks, driven on the falling edge
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph == 15) ? 0 : ph + 1;
      baud_tick = tick_en && ph == 0;
      if (baud_tick) tick_cnt++;
    end
  end

  initial begin
    logic t, e;
    bit busy_prev = 1'b0;
    forever begin
      @(posedge clk);
      t = baud_tick;
      #1;
      if (frame_done === 1'b1) done_cnt++;
      if (busy_prev && busy === 1'b0) fall_cnt++;
      busy_prev = busy === 1'b1;
      if (t && busy === 1'b1 && mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txd_bit: got %0b expected no bit (nothing queued)", txd);
        end else begin
          e = exp_q.pop_front();
          if (txd !== e) begin
            errors++;
            $display("FAIL txd_bit: got %0b expected %0b (%0d bits left)", txd, e, exp_q.size());
          end
        end
      end
    end
  end

  initial begin
    int d0, f0, acc;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);
    reset = 1'b1;

    tick_en = 1'b1;
    parity_mode = 2'b01; stop2 = 1'b1;
    d0 = done_cnt;
    exp_bits("010100101011");
    push(8'hA5);
    wait_drain("even2");
    check("even2_done", done_cnt - d0, 1);
    check("even2_busy", busy, 0);

    parity_mode = 2'b10; stop2 = 1'b0;
    d0 = done_cnt;
    exp_bits("01000000001");
    push(8'h01);
    wait_drain("odd1");
    check("odd1_done", done_cnt - d0, 1);
    parity_mode = 2'b00;
    exp_bits("0100000001");
    push(8'h01);
    wait_drain("none1");

    stop_ticks();
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      in_data = 8'(i);
      in_valid = 1'b1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_accepted", acc, 4);
    check("full_ready", in_ready, 0);
    check("full_level", fifo_level, 4);
    exp_bits("0100000001"); exp_bits("0010000001");
    exp_bits("0110000001"); exp_bits("0001000001");
    d0 = done_cnt; f0 = fall_cnt;
    tick_en = 1'b1;
    wait_drain("full");
    check("full_done", done_cnt - d0, 4);
    check("full_busy_falls", fall_cnt - f0, 1);

    stop_ticks();
    push(8'h00);
    push(8'hFF);
    exp_bits("0000000001"); exp_bits("0111111111");
    d0 = done_cnt; f0 = fall_cnt;
    tick_en = 1'b1;
    wait_drain("b2b");
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_busy_falls", fall_cnt - f0, 1);

    stop_ticks();
    parity_mode = 2'b01; stop2 = 1'b0;
    push(8'hA5);
    push(8'h3C);
    exp_bits("01010010101"); exp_bits("0001111001");
    d0 = done_cnt;
    tick_en = 1'b1;
    wait_ticks(4);
    parity_mode = 2'b00;
    wait_drain("cfg");
    check("cfg_done", done_cnt - d0, 2);

    stop_ticks();
    mon_en = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    tick_en = 1'b1;
    wait_ticks(4);
    @(posedge clk);
    #3;
    check("mid_txd", txd, 0);
    check("mid_level", fifo_level, 2);
    check("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("arst_txd", txd, 1);
    check("arst_busy", busy, 0);
    check("arst_level", fifo_level, 0);
    check("arst_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    check("inrst_txd", txd, 1);
    check("inrst_busy", busy, 0);
    reset = 1'b1;
    wait_ticks(4);
    @(negedge clk);
    check("post_txd", txd, 1);
    check("post_busy", busy, 0);
    check("post_level", fifo_level, 0);
    exp_q.delete();
    mon_en = 1'b1;
    exp_bits("0001111001");
    push(8'h3C);
    wait_drain("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
